// File: rtl/keypad_scanner.sv
// 7x5 matrix keypad scanner with scan-level debounce; key appears one cycle after the accepting scan end.
// Output is a 1-entry valid/ready register: an accepted key is dropped (sticky overflow) if still full.
module keypad_scanner #(
    parameter int ROW_DWELL      = 50000,
    parameter int DEBOUNCE_COUNT = 20
) (
    input  logic       clock,
    input  logic       reset,
    output logic [6:0] row_drive,
    input  logic [4:0] col_in,
    output logic [5:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_down,
    output logic       overflow
);
    localparam int             DW         = $clog2(ROW_DWELL);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(ROW_DWELL - 1);
    localparam logic [7:0]     DEB        = 8'(DEBOUNCE_COUNT);

    typedef enum logic [1:0] {IDLE, CONFIRM, HELD} state_t;

    logic [4:0]    col_s1_q, col_s2_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [2:0]    row_q, row_d;
    logic [6:0]    row_drive_q, row_drive_d;
    logic [1:0]    hits_q, hits_d;
    logic [5:0]    hit_code_q, hit_code_d;

    state_t        state_q;
    logic [7:0]    count_q;
    logic [5:0]    cand_q;
    logic [5:0]    key_code_q;
    logic          key_valid_q, key_down_q, overflow_q;

    logic          sample_en, scan_end;
    logic [2:0]    row_hits, row_col, hit_sum;
    logic [1:0]    base_hits;
    logic [5:0]    row_code;
    logic          scan_none, scan_single, accept, load;

    always_comb begin
        row_hits = 3'd0;
        row_col  = 3'd0;
        for (int c = 4; c >= 0; c--) begin
            if (!col_s2_q[c]) begin
                row_hits = row_hits + 3'd1;
                row_col  = 3'(c);
            end
        end
    end

    // hits_q saturates at 2: beyond "more than one key" the count carries no information
    always_comb begin
        sample_en   = (dwell_q == DWELL_LAST);
        scan_end    = sample_en && (row_q == 3'd6);
        base_hits   = (row_q == 3'd0) ? 2'd0 : hits_q;
        hit_sum     = {1'b0, base_hits} + row_hits;
        row_code    = 6'({row_q, 2'b00}) + 6'(row_q) + 6'(row_col);
        hits_d      = hits_q;
        hit_code_d  = hit_code_q;
        dwell_d     = dwell_q + DW'(1);
        row_d       = row_q;
        row_drive_d = row_drive_q;
        if (sample_en) begin
            hits_d      = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
            if (row_hits != 3'd0) hit_code_d = row_code;
            dwell_d     = '0;
            row_d       = (row_q == 3'd6) ? 3'd0 : row_q + 3'd1;
            row_drive_d = {row_drive_q[5:0], row_drive_q[6]};
        end
    end

    always_comb begin
        scan_none   = scan_end && (hits_d == 2'd0);
        scan_single = scan_end && (hits_d == 2'd1);
        accept      = scan_single &&
                      (((state_q == IDLE) && (DEB == 8'd1)) ||
                       ((state_q == CONFIRM) && (hit_code_d == cand_q) && (count_q + 8'd1 == DEB)));
        load        = accept && (!key_valid_q || key_ready);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_s1_q    <= 5'b11111;
            col_s2_q    <= 5'b11111;
            dwell_q     <= '0;
            row_q       <= 3'd0;
            row_drive_q <= 7'b1111110;
            hits_q      <= 2'd0;
            hit_code_q  <= 6'd0;
        end else begin
            col_s1_q    <= col_in;
            col_s2_q    <= col_s1_q;
            dwell_q     <= dwell_d;
            row_q       <= row_d;
            row_drive_q <= row_drive_d;
            hits_q      <= hits_d;
            hit_code_q  <= hit_code_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= 8'd0;
            cand_q      <= 6'd0;
            key_code_q  <= 6'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (scan_end) begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            state_q    <= HELD;
                            count_q    <= 8'd0;
                            key_down_q <= 1'b1;
                        end else if (scan_single) begin
                            state_q <= CONFIRM;
                            cand_q  <= hit_code_d;
                            count_q <= 8'd1;
                        end
                    end
                    CONFIRM: begin
                        if (accept) begin
                            state_q    <= HELD;
                            count_q    <= 8'd0;
                            key_down_q <= 1'b1;
                        end else if (scan_single && (hit_code_d == cand_q)) begin
                            count_q <= count_q + 8'd1;
                        end else if (scan_single) begin
                            cand_q  <= hit_code_d;
                            count_q <= 8'd1;
                        end else begin
                            state_q <= IDLE;
                            count_q <= 8'd0;
                        end
                    end
                    HELD: begin
                        if (scan_none && (count_q + 8'd1 == DEB)) begin
                            state_q    <= IDLE;
                            count_q    <= 8'd0;
                            key_down_q <= 1'b0;
                        end else if (scan_none) begin
                            count_q <= count_q + 8'd1;
                        end else begin
                            count_q <= 8'd0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        count_q <= 8'd0;
                    end
                endcase
            end
            // a load in the same cycle as a consume wins, keeping valid high
            if (load) begin
                key_code_q  <= hit_code_d;
                key_valid_q <= 1'b1;
            end else if (key_valid_q && key_ready) begin
                key_valid_q <= 1'b0;
            end
            if (accept && !load) overflow_q <= 1'b1;
        end
    end

    assign row_drive = row_drive_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with ROW_DWELL=4, DEBOUNCE_COUNT=3 and a modelled key matrix.
module tb_keypad_scanner;
    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  row_drive;
    logic [4:0]  col_in;
    logic [5:0]  key_code;
    logic        key_valid, key_ready, key_down, overflow;
    logic [34:0] keys;
    int          n_checks = 0;
    int          n_pass   = 0;

    keypad_scanner #(.ROW_DWELL(4), .DEBOUNCE_COUNT(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .row_drive (row_drive),
        .col_in    (col_in),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_down  (key_down),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    // key matrix: a closed key shorts its row strobe onto its column line
    always_comb begin
        col_in = 5'b11111;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 5; c++)
                if (!row_drive[r] && keys[r*5+c]) col_in[c] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // return at the first negedge of a new scan (row 0, first dwell cycle)
    task automatic to_scan_start(input string tag);
        int n = 0;
        while (row_drive != 7'b0111111 && n < 64) begin @(negedge clock); n++; end
        while (row_drive == 7'b0111111 && n < 64) begin @(negedge clock); n++; end
        chk(tag, row_drive, 7'b1111110);
    endtask

    task automatic watch(input int n, output int first, output int pulses, output logic [5:0] code);
        first = -1; pulses = 0; code = 6'd0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            if (key_valid) begin
                if (first < 0) begin first = k; code = key_code; end
                pulses++;
            end
        end
    endtask

    task automatic watch_down(input int n, output int first_low);
        first_low = -1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            if (!key_down && first_low < 0) first_low = k;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first, pulses, first_low, bad;
        logic [5:0]  code;
        logic [6:0]  exp_row;

        reset = 1'b1; keys = '0; key_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_row_drive", row_drive, 7'b1111110);
        chk("rst_key_code", key_code, 6'd0);
        chk("rst_key_valid", key_valid, 1'b0);
        chk("rst_key_down", key_down, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        reset = 1'b0;

        // idle walk: each row held 4 cycles, wrap after row 6
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            exp_row = ~(7'(1) << ((i / 4) % 7));
            chk($sformatf("row_walk_%0d", i), row_drive, exp_row);
            if (key_valid) bad++;
            @(negedge clock);
        end
        chk("idle_no_valid", bad, 0);

        // single key (2,3) -> code 13 after the third scan
        key_ready = 1'b1;
        to_scan_start("sync_press");
        keys[13] = 1'b1;
        watch(112, first, pulses, code);
        chk("press_first_cycle", first, 84);
        chk("press_pulses", pulses, 1);
        chk("press_code", code, 13);
        chk("press_key_down", key_down, 1'b1);

        // release -> key_down drops after 3 empty scans
        to_scan_start("sync_release");
        keys = '0;
        watch_down(112, first_low);
        chk("release_fall_cycle", first_low, 84);

        // bounce on key (1,1) toggling every 10 cycles never stays stable 3 scans
        to_scan_start("sync_bounce");
        bad = 0;
        for (int k = 0; k < 280; k++) begin
            if (k % 10 == 0) keys[6] = ~keys[6];
            @(negedge clock);
            if (key_valid || key_down) bad++;
        end
        chk("bounce_accepts", bad, 0);
        keys = '0;
        repeat (56) @(negedge clock);

        // two keys -> MULTI; dropping one leaves (0,0) accepted
        to_scan_start("sync_multi");
        keys[0] = 1'b1; keys[34] = 1'b1;
        watch(112, first, pulses, code);
        chk("multi_pulses", pulses, 0);
        chk("multi_key_down", key_down, 1'b0);
        keys[34] = 1'b0;
        watch(112, first, pulses, code);
        chk("multi_rel_first", first, 84);
        chk("multi_rel_code", code, 0);
        chk("multi_rel_pulses", pulses, 1);
        keys = '0;
        watch_down(112, first_low);
        chk("multi_fall_cycle", first_low, 84);

        // no consumer: 4 is held, 9 is dropped
        key_ready = 1'b0;
        to_scan_start("sync_ovf");
        chk("ovf_before", overflow, 1'b0);
        keys[4] = 1'b1;
        watch(84, first, pulses, code);
        chk("ovf_first_cycle", first, 84);
        chk("ovf_first_code", code, 4);
        keys[4] = 1'b0;
        watch_down(84, first_low);
        chk("ovf_rel4_fall", first_low, 84);
        keys[9] = 1'b1;
        repeat (84) @(negedge clock);
        chk("ovf_code_held", key_code, 4);
        chk("ovf_valid_held", key_valid, 1'b1);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_key9_down", key_down, 1'b1);
        keys[9] = 1'b0;
        repeat (84) @(negedge clock);
        chk("ovf_key9_up", key_down, 1'b0);
        key_ready = 1'b1;
        @(negedge clock);
        chk("ovf_consumed", key_valid, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);

        // reset in CONFIRM with count 2 abandons progress
        to_scan_start("sync_rst");
        keys[17] = 1'b1;
        repeat (60) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midrst_row_drive", row_drive, 7'b1111110);
        chk("midrst_key_code", key_code, 6'd0);
        chk("midrst_key_valid", key_valid, 1'b0);
        chk("midrst_key_down", key_down, 1'b0);
        chk("midrst_overflow", overflow, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        watch(112, first, pulses, code);
        chk("postrst_first_cycle", first, 84);
        chk("postrst_code", code, 17);
        chk("postrst_pulses", pulses, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter ROW_DWELL, default 50000, meaning clock cycles each row is driven (1 ms at 50 MHz); legal minimum 4.
REQ-002 The block SHALL have parameter DEBOUNCE_COUNT, default 20, meaning consecutive full scans needed to accept a press or a release; legal range 1..255.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port row_drive, output, 7 bits: active-low row strobe; exactly one bit is 0 at all times.
REQ-006 The block SHALL have port col_in, input, 5 bits: raw active-low column sense, asynchronous to clock.
REQ-007 The block SHALL have port key_code, output, 6 bits: accepted key, equal to row*5+col, range 0..34.
REQ-008 The block SHALL have port key_valid, output, 1 bit: key_code holds an unconsumed key.
REQ-009 The block SHALL have port key_ready, input, 1 bit: consumer accepts key_code this cycle.
REQ-010 The block SHALL have port key_down, output, 1 bit: level, high from acceptance of a key until its release is debounced.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag, set when an accepted key is dropped.

Function
REQ-012 col_in SHALL pass through a 2-flop synchronizer; only the synchronized value is used.
REQ-013 A dwell counter SHALL count 0..ROW_DWELL-1 per row; the row index SHALL advance 0..6 and wrap from 6 to 0.
REQ-014 Columns SHALL be sampled on the last dwell cycle of each row; a 0 in column c marks key (row, c).
REQ-015 A full scan SHALL end on the last dwell cycle of row 6, and SHALL classify as NONE (0 keys), SINGLE(code) (exactly 1 key) or MULTI (2 or more keys).
REQ-016 The FSM SHALL have three states, IDLE, CONFIRM and HELD, with a shared 8-bit count, and SHALL change state only at scan end.
REQ-017 In IDLE: SINGLE(k) SHALL go to CONFIRM with candidate=k and count=1; NONE and MULTI SHALL stay in IDLE.
REQ-018 In CONFIRM: SINGLE(candidate) SHALL increment count; SINGLE(other) SHALL restart with candidate=other and count=1; NONE or MULTI SHALL go to IDLE.
REQ-019 In CONFIRM, when count reaches DEBOUNCE_COUNT, the key SHALL be accepted, the FSM SHALL go to HELD with count=0, and key_down SHALL be set to 1.
REQ-020 With DEBOUNCE_COUNT=1, a SINGLE scan in IDLE SHALL accept the key immediately.
REQ-021 In HELD: NONE SHALL increment count, while SINGLE or MULTI SHALL reset count to 0; at count=DEBOUNCE_COUNT the FSM SHALL go to IDLE and clear key_down.
REQ-022 No new key SHALL be accepted while in HELD; there is no auto-repeat.
REQ-023 On acceptance, the key SHALL be loaded into the 1-entry output register when key_valid=0 or key_ready=1; otherwise the key SHALL be dropped and overflow set to 1.
REQ-024 key_code and key_valid SHALL be registered and SHALL appear one cycle after the accepting scan-end cycle.
REQ-025 key_valid SHALL clear on any cycle with key_valid and key_ready both 1, unless a load occurs in that same cycle.
REQ-026 On a simultaneous load and consume, the new code SHALL load and key_valid SHALL stay 1.
REQ-027 key_code SHALL hold its value while key_valid=1; key_ready while key_valid=0 SHALL be ignored.
REQ-028 overflow SHALL clear only on reset.
REQ-029 Press latency SHALL be at most (DEBOUNCE_COUNT+1)*7*ROW_DWELL+3 cycles from a stable key press to key_valid.

Reset
REQ-030 While reset=1, regardless of clock, outputs SHALL be row_drive=7'b1111110, key_code=0, key_valid=0, key_down=0, overflow=0.
REQ-031 While reset=1, internal state SHALL be FSM=IDLE, count=0, dwell=0, row=0, synchronizer=5'b11111.
REQ-032 A reset asserted mid-scan or mid-debounce SHALL abandon all progress; scanning SHALL restart at row 0 on the first clock after deassertion.

Verification (ROW_DWELL=4, DEBOUNCE_COUNT=3, bench models matrix: col_in[c]=0 iff row_drive[r]=0 and key (r,c) closed)
REQ-033 The bench SHALL check: no key, run 200 cycles -> row_drive walks 1111110, 1111101, ... with each value held 4 cycles, wraps after row 6, and key_valid stays 0.
REQ-034 The bench SHALL check: close key (2,3) from a scan start, key_ready=1 -> key_code=13, key_valid pulses for exactly 1 cycle after the 3rd full scan, and key_down=1.
REQ-035 The bench SHALL check: release key (2,3) -> key_down drops after 3 consecutive NONE scans; a bounce toggled every 10 cycles -> no acceptance.
REQ-036 The bench SHALL check: close keys (0,0) and (6,4) together -> MULTI, no key_valid; then release (6,4) -> key_code=0 after 3 scans.
REQ-037 The bench SHALL check: key_ready=0, press and release 4 then 9 -> key_code=4 held, overflow=1; assert key_ready -> key_valid=0 next cycle.
REQ-038 The bench SHALL check: assert reset during CONFIRM (count=2), then release -> all outputs at reset values; the key still held is accepted only after 3 fresh scans.
